ula_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer that shares one combinational ULA instance between two requesters. It registers the winning request's operands, holds them on the ULA inputs for a fixed settle window, and captures the result. It returns the result, status and an error flag with a one-cycle acknowledge. It sits between the ULA and the control units that issue arithmetic operations.

---
 rtl/ula_arbiter.sv | 80 ++++++++
 tb/tb_ula_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ula_arbiter.sv
// ula_arbiter: round-robin arbiter that sequences two requesters onto one shared combinational ULA
module ula_arbiter #(
    parameter int WIDTH = 28
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [3:0]       select0,
    input  logic [3:0]       select1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] result,
    output logic             status,
    output logic             error,
    output logic             busy,
    output logic [WIDTH-1:0] ulaA,
    output logic [WIDTH-1:0] ulaB,
    output logic [3:0]       ulaSelect,
    input  logic [WIDTH-1:0] ulaOutput,
    input  logic             ulaStatus
);
    typedef enum logic [1:0] {IDLE, EXEC, HOLD, DONE} state_t;
    state_t           state, state_nx;
    logic             prio, grant_id, take, win, drive, bad;
    logic [WIDTH-1:0] op_a, op_b, cap_res;
    logic [3:0]       op_sel;
    logic             cap_st;
    always_comb begin
        take     = state == IDLE && (req0 || req1);
        win      = (req0 && req1) ? prio : req1;
        state_nx = state == IDLE ? (take ? EXEC : IDLE) :
                   state == EXEC ? HOLD :
                   state == HOLD ? DONE : IDLE;
    end
    // DIV by zero and undefined opcodes discard whatever the ULA produced
    always_comb begin
        bad     = op_sel >= 4'd10 || (op_sel == 4'd9 && op_a == '0);
        cap_res = (bad || op_sel == 4'd3) ? '0 : ulaOutput;
        cap_st  = !bad && (op_sel == 4'd3 || op_sel == 4'd4 || op_sel == 4'd5) && ulaStatus;
    end
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            prio     <= 1'b0;
            grant_id <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_sel   <= '0;
            result   <= '0;
            status   <= 1'b0;
            error    <= 1'b0;
        end else begin
            state <= state_nx;
            if (take) begin
                op_a     <= win ? a1 : a0;
                op_b     <= win ? b1 : b0;
                op_sel   <= win ? select1 : select0;
                grant_id <= win;
                prio     <= ~win;
            end
            if (state == HOLD) begin
                result <= cap_res;
                status <= cap_st;
                error  <= bad;
            end
        end
    end
    assign drive     = state == EXEC || state == HOLD;
    assign ulaA      = drive ? op_a : '0;
    assign ulaB      = drive ? op_b : '0;
    assign ulaSelect = drive ? op_sel : 4'b0000;
    assign busy      = state != IDLE;
    assign ack0      = state == DONE && !grant_id;
    assign ack1      = state == DONE && grant_id;
endmodule

// File: tb/tb_ula_arbiter.sv
// tb_ula_arbiter: scoreboard bench with a behavioural ULA stand-in and a rule-level reference model
module tb_ula_arbiter;
    localparam int W = 28;
    typedef struct packed {
        logic [W-1:0] res;
        logic         st;
        logic         err;
    } exp_t;

    logic         clock, resetN, req0, req1, ack0, ack1, status, error, busy, ulaStatus;
    logic [W-1:0] a0, b0, a1, b1, result, ulaA, ulaB, ulaOutput;
    logic [3:0]   select0, select1, ulaSelect;
    exp_t         q0[$], q1[$];
    int           checks = 0, errors = 0;

    ula_arbiter #(.WIDTH(W)) dut (
        .clock(clock), .resetN(resetN), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .select0(select0), .select1(select1),
        .ack0(ack0), .ack1(ack1), .result(result), .status(status), .error(error),
        .busy(busy), .ulaA(ulaA), .ulaB(ulaB), .ulaSelect(ulaSelect),
        .ulaOutput(ulaOutput), .ulaStatus(ulaStatus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ULA stand-in; non-comparison ops and error cases emit junk status/output on purpose
    function automatic logic [W:0] ula_fn(input logic [3:0] s, input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        logic signed [W-1:0] o;
        logic st;
        o  = a + b;
        st = a[0];
        case (s)
            4'd0: o = a + b;
            4'd1: o = b - a;
            4'd2: o = -b;
            4'd3: begin o = a - b; st = (a == b); end
            4'd4: begin o = (a > b) ? a : b; st = (a > b); end
            4'd5: begin o = (a < b) ? a : b; st = (a < b); end
            4'd6: o = a & b;
            4'd7: o = a | b;
            4'd8: o = a * b;
            4'd9: o = (a == 0) ? '1 : b / a;
            default: st = 1'b1;
        endcase
        return {st, o};
    endfunction

    always_comb {ulaStatus, ulaOutput} = ula_fn(ulaSelect, ulaA, ulaB);

    function automatic exp_t model(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] u;
        u = ula_fn(s, a, b);
        if (s >= 4'd10 || (s == 4'd9 && a == '0)) return '{res: '0, st: 1'b0, err: 1'b1};
        if (s == 4'd3) return '{res: '0, st: u[W], err: 1'b0};
        if (s == 4'd4 || s == 4'd5) return '{res: u[W-1:0], st: u[W], err: 1'b0};
        return '{res: u[W-1:0], st: 1'b0, err: 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        check("dual_ack", 32'(ack0 & ack1), 0);
        if (!busy || ack0 || ack1) check("ula_idle_zero", 32'(|{ulaA, ulaB, ulaSelect}), 0);
        if (ack0) begin
            check("ack0_expected", 32'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("res0", 32'(result), 32'(e.res));
                check("st0", 32'(status), 32'(e.st));
                check("err0", 32'(error), 32'(e.err));
            end
        end
        if (ack1) begin
            check("ack1_expected", 32'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("res1", 32'(result), 32'(e.res));
                check("st1", 32'(status), 32'(e.st));
                check("err1", 32'(error), 32'(e.err));
            end
        end
    end

    task automatic run(input int i, input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e, output int lat);
        if (i == 0) begin q0.push_back(e); a0 = a; b0 = b; select0 = s; req0 = 1'b1; end
        else begin q1.push_back(e); a1 = a; b1 = b; select1 = s; req1 = 1'b1; end
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!(i == 0 ? ack0 : ack1) && lat < 20);
        if (lat >= 20) check("ack_timeout", 32'(i == 0 ? ack0 : ack1), 1);
        if (i == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic op(input int i, input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e, input string name);
        int lat;
        @(negedge clock);
        run(i, s, a, b, e, lat);
        check(name, lat, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, l1, lat;
        resetN = 1'b0; req0 = 0; req1 = 0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; select0 = '0; select1 = '0;
        repeat (2) @(negedge clock);
        check("rst_ack", {ack0, ack1}, 0);
        check("rst_busy", busy, 0);
        check("rst_result", 32'(result), 0);
        check("rst_flags", {status, error}, 0);
        // contention straight out of reset: requester 0 first, then 1 four cycles later
        resetN = 1'b1;
        fork
            run(0, 4'd1, 28'd2, 28'd10, '{res: 28'd8, st: 1'b0, err: 1'b0}, l0);
            run(1, 4'd8, 28'hFFFFFFC, 28'd6, '{res: 28'hFFFFFE8, st: 1'b0, err: 1'b0}, l1);
        join
        check("cont_lat0", l0, 3);
        check("cont_lat1", l1, 7);
        @(negedge clock);
        fork
            run(0, 4'd0, 28'd1, 28'd2, '{res: 28'd3, st: 1'b0, err: 1'b0}, l0);
            run(1, 4'd0, 28'd4, 28'd5, '{res: 28'd9, st: 1'b0, err: 1'b0}, l1);
        join
        check("prio_back_lat0", l0, 3);
        check("prio_back_lat1", l1, 7);
        op(0, 4'd0, 28'd5, 28'd3, '{res: 28'd8, st: 1'b0, err: 1'b0}, "add_lat");
        op(0, 4'd3, 28'd7, 28'd7, '{res: 28'd0, st: 1'b1, err: 1'b0}, "igual_lat");
        op(1, 4'd4, 28'd9, 28'd4, '{res: 28'd9, st: 1'b1, err: 1'b0}, "maior_lat");
        op(1, 4'd5, 28'd9, 28'd4, '{res: 28'd4, st: 1'b0, err: 1'b0}, "menor_lat");
        op(0, 4'd9, 28'd0, 28'd100, '{res: 28'd0, st: 1'b0, err: 1'b1}, "div0_lat");
        op(1, 4'd12, 28'd3, 28'd4, '{res: 28'd0, st: 1'b0, err: 1'b1}, "badop_lat");
        op(0, 4'd9, 28'd5, 28'd100, '{res: 28'd20, st: 1'b0, err: 1'b0}, "div_lat");
        op(0, 4'd0, 28'h7FFFFFF, 28'd1, '{res: 28'h8000000, st: 1'b0, err: 1'b0}, "wrap_lat");
        op(1, 4'd2, 28'd0, 28'd1, '{res: 28'hFFFFFFF, st: 1'b0, err: 1'b0}, "comp_lat");
        op(1, 4'd6, 28'hF0, 28'h3C, '{res: 28'h30, st: 1'b0, err: 1'b0}, "and_lat");
        op(0, 4'd7, 28'hF0, 28'h0F, '{res: 28'hFF, st: 1'b0, err: 1'b0}, "or_lat");
        // reset during HOLD drops the op; the still-pending request then reissues
        @(negedge clock);
        q1.push_back('{res: 28'd33, st: 1'b0, err: 1'b0});
        a1 = 28'd11; b1 = 28'd22; select1 = 4'd0; req1 = 1'b1;
        @(negedge clock);
        check("exec_busy", busy, 1);
        @(negedge clock);
        #1 resetN = 1'b0;
        #1;
        check("midrst_ack", {ack0, ack1}, 0);
        check("midrst_busy", busy, 0);
        check("midrst_result", 32'(result), 0);
        check("midrst_ula", 32'(|{ulaA, ulaB, ulaSelect}), 0);
        @(negedge clock);
        resetN = 1'b1;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!ack1 && lat < 20);
        check("reissue_lat", lat, 3);
        req1 = 1'b0;
        @(negedge clock);
        fork
            begin
                for (int n = 0; n < 30; n++) begin
                    logic [3:0] s;
                    logic [W-1:0] a, b;
                    int lt;
                    repeat ($urandom_range(0, 3)) @(negedge clock);
                    s = 4'($urandom_range(0, 15));
                    a = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom());
                    b = W'($urandom());
                    run(0, s, a, b, model(s, a, b), lt);
                    check("rand_lat0", 32'(lt <= 8), 1);
                end
            end
            begin
                for (int n = 0; n < 30; n++) begin
                    logic [3:0] s;
                    logic [W-1:0] a, b;
                    int lt;
                    repeat ($urandom_range(0, 3)) @(negedge clock);
                    s = 4'($urandom_range(0, 15));
                    a = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom());
                    b = W'($urandom());
                    run(1, s, a, b, model(s, a, b), lt);
                    check("rand_lat1", 32'(lt <= 8), 1);
                end
            end
        join
        repeat (3) @(negedge clock);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
